// File: rtl/sd_bd_queue_pkg.sv
// Shared defaults and release-event classification for the SD buffer-descriptor queue.
package sd_bd_queue_pkg;

    localparam int unsigned SD_BD_DATA_W       = 32;
    localparam int unsigned SD_BD_WORDS_PER_BD = 2;
    localparam int unsigned SD_BD_DEPTH        = 8;

    typedef enum logic [1:0] {
        REL_NONE     = 2'd0,
        REL_OK       = 2'd1,
        REL_SPURIOUS = 2'd2
    } rel_ev_e;

    // A completion edge only frees a slot if some descriptor was fully read and not yet released.
    function automatic rel_ev_e classify_release(input logic rise, input logic have_outstanding);
        if (!rise) begin
            return REL_NONE;
        end
        return have_outstanding ? REL_OK : REL_SPURIOUS;
    endfunction

endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor word store: one write port, one registered read port.
module sd_bd_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Output register holds its value whenever no read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue: host writes fixed-size descriptors, data master reads them in order,
// completion edges release slots. Tracks free, pending and outstanding descriptors.
module sd_bd_queue
    import sd_bd_queue_pkg::*;
#(
    parameter int unsigned DATA_W       = SD_BD_DATA_W,
    parameter int unsigned WORDS_PER_BD = SD_BD_WORDS_PER_BD,
    parameter int unsigned BD_DEPTH     = SD_BD_DEPTH,
    localparam int unsigned CNT_W       = $clog2(BD_DEPTH + 1),
    localparam int unsigned AW          = $clog2(BD_DEPTH * WORDS_PER_BD),
    localparam int unsigned WC_W        = $clog2(WORDS_PER_BD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              we_m,
    input  logic [DATA_W-1:0] dat_in_m,
    output logic [CNT_W-1:0]  free_bd,
    output logic              wr_err,
    input  logic              re_s,
    output logic              ack_o_s,
    output logic [DATA_W-1:0] dat_out_s,
    output logic [CNT_W-1:0]  bd_pend_s,
    input  logic              a_cmp,
    output logic              rel_err
);

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_BD - 1);

    logic [AW-1:0]    wp_q,      wp_d;
    logic [AW-1:0]    rp_q,      rp_d;
    logic [WC_W-1:0]  wc_q,      wc_d;
    logic [WC_W-1:0]  rc_q,      rc_d;
    logic [CNT_W-1:0] free_q,    free_d;
    logic [CNT_W-1:0] pend_q,    pend_d;
    logic             ack_q,     ack_d;
    logic             wr_err_q,  wr_err_d;
    logic             rel_err_q, rel_err_d;
    logic             a_cmp_q,   a_cmp_d;

    logic             wr_ok;
    logic             commit;
    logic             rd_ok;
    logic             rd_last;
    logic [CNT_W-1:0] outstanding;
    rel_ev_e          rel_ev;

    // Event decode uses pre-edge counts only, so simultaneous events combine as a net sum.
    always_comb begin
        outstanding = CNT_W'(BD_DEPTH) - free_q - pend_q;
        wr_ok       = we_m & (free_q != '0) & ~flush;
        commit      = wr_ok & (wc_q == WC_LAST);
        rd_ok       = re_s & (pend_q != '0) & ~flush;
        rd_last     = rd_ok & (rc_q == WC_LAST);
        rel_ev      = classify_release(a_cmp & ~a_cmp_q & ~flush, outstanding != '0);
    end

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        wc_d      = wc_q;
        rc_d      = rc_q;
        free_d    = free_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        wr_err_d  = 1'b0;
        rel_err_d = 1'b0;
        a_cmp_d   = a_cmp;

        if (flush) begin
            wp_d   = '0;
            rp_d   = '0;
            wc_d   = '0;
            rc_d   = '0;
            free_d = CNT_W'(BD_DEPTH);
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                wp_d = wp_q + AW'(1);
                wc_d = commit ? '0 : wc_q + WC_W'(1);
            end
            if (rd_ok) begin
                rp_d = rp_q + AW'(1);
                rc_d = rd_last ? '0 : rc_q + WC_W'(1);
            end
            wr_err_d  = we_m & (free_q == '0);
            ack_d     = rd_ok;
            rel_err_d = (rel_ev == REL_SPURIOUS);
            free_d    = free_q - CNT_W'(commit) + CNT_W'(rel_ev == REL_OK);
            pend_d    = pend_q + CNT_W'(commit) - CNT_W'(rd_last);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            wc_q      <= '0;
            rc_q      <= '0;
            free_q    <= CNT_W'(BD_DEPTH);
            pend_q    <= '0;
            ack_q     <= 1'b0;
            wr_err_q  <= 1'b0;
            rel_err_q <= 1'b0;
            a_cmp_q   <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            wc_q      <= wc_d;
            rc_q      <= rc_d;
            free_q    <= free_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            wr_err_q  <= wr_err_d;
            rel_err_q <= rel_err_d;
            a_cmp_q   <= a_cmp_d;
        end
    end

    sd_bd_ram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst),
        .we    (wr_ok),
        .waddr (wp_q),
        .wdata (dat_in_m),
        .re    (rd_ok),
        .raddr (rp_q),
        .rdata (dat_out_s)
    );

    assign free_bd   = free_q;
    assign bd_pend_s = pend_q;
    assign ack_o_s   = ack_q;
    assign wr_err    = wr_err_q;
    assign rel_err   = rel_err_q;

endmodule

// File: doc/sd_bd_queue.md
# sd_bd_queue

Parametrised buffer-descriptor queue for the SD card controller. The host/Wishbone side writes descriptors as a fixed number of words; the data-master side reads them back in order, one word per request. A completion strobe from the transfer engine then releases each descriptor's slot. It supersedes the fixed 16/32-bit descriptor store. It adds configurable width, depth and words-per-descriptor, explicit pending/outstanding accounting, overflow and spurious-release error flags, and a synchronous flush.

## Interface
Parameters:
- DATA_W, 32: descriptor word width.
- WORDS_PER_BD, 2: words per descriptor (power of two, ≥2).
- BD_DEPTH, 8: descriptor slots (power of two, ≥2).

Derived values: CNT_W = clog2(BD_DEPTH+1); AW = clog2(BD_DEPTH*WORDS_PER_BD).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the whole queue.
- we_m  in  1  host word write strobe.
- dat_in_m  in  DATA_W  host write data.
- free_bd  out  CNT_W  slots neither committed nor awaiting release.
- wr_err  out  1  one-cycle pulse: write dropped because free_bd==0.
- re_s  in  1  data-master word read request.
- ack_o_s  out  1  one-cycle pulse: dat_out_s valid.
- dat_out_s  out  DATA_W  read data, registered.
- bd_pend_s  out  CNT_W  committed descriptors not yet fully read.
- a_cmp  in  1  transfer-complete level; its rising edge releases one slot.
- rel_err  out  1  one-cycle pulse: release with no outstanding descriptor.

## Operation
- Storage holds BD_DEPTH*WORDS_PER_BD words. Word write pointer wp, read pointer rp (AW bits) wrap naturally modulo size.
- **Write side.** we_m with free_bd≠0 stores dat_in_m at wp, increments wp and the word counter wc.
  - When wc==WORDS_PER_BD-1 the descriptor commits: wc→0, free_bd−1, bd_pend_s+1, all on that same edge.
  - A partial descriptor occupies no count until it commits.
  - we_m with free_bd==0: nothing stored, wp/wc unchanged, wr_err=1 next cycle.
- **Read side.** re_s with bd_pend_s≠0 latches mem[rp] into dat_out_s and sets ack_o_s=1 on the next edge, then increments rp and the word counter rc.
  - On the last word (rc==WORDS_PER_BD-1): rc→0, bd_pend_s−1.
  - re_s with bd_pend_s==0 is ignored: no ack, dat_out_s holds.
- **Release.** Outstanding = BD_DEPTH − free_bd − bd_pend_s (fully read, not released).
  - A rising edge of a_cmp (a_cmp & ~a_cmp_q) with outstanding>0 gives free_bd+1.
  - A rising edge with outstanding==0 changes nothing and pulses rel_err.
  - a_cmp held high releases exactly once.
- **Simultaneous events.** Commit, last-word read and release on one edge all apply; free_bd and bd_pend_s take the net sum (commit+release leaves free_bd unchanged). Outstanding is evaluated from pre-edge values.
- **flush.** Has priority over all other inputs. Resets wp, rp, wc, rc, free_bd=BD_DEPTH, bd_pend_s=0, ack_o_s=0, wr_err=0, rel_err=0. a_cmp_q tracks a_cmp; dat_out_s holds its value.

## Timing
- Reset values: free_bd=BD_DEPTH, bd_pend_s=0, ack_o_s=0, dat_out_s=0, wr_err=0, rel_err=0, a_cmp_q=0, all pointers and counters 0.
- Write to committed visibility: bd_pend_s updates on the edge that stores the last word. The first re_s may come the following cycle.
- Read latency: 1 cycle from re_s to ack_o_s/dat_out_s. Back-to-back re_s gives consecutive acks.
- Write-to-read same address in the same cycle cannot occur, because a word is readable only after its descriptor commits.
- Reset asserted mid-descriptor discards the partial descriptor; no error pulse.

## Structure
- Defaults for DATA_W, WORDS_PER_BD and BD_DEPTH belong in the shared sd_defines.v alongside the existing BD constants, so the register file and data master pick up the same values.
- One sub-module: sd_bd_ram, a simple dual-port array (one write port, one registered read port, DATA_W × 2^AW) with no reset on the array.
- Counters and control stay in sd_bd_queue.

## Test plan
Defaults DATA_W=32, WORDS_PER_BD=2, BD_DEPTH=8 unless stated.
- Reset, then write 0xA0000000, 0x00000010 → free_bd=7, bd_pend_s=1. Two re_s → ack on the next two cycles, dat_out_s=0xA0000000 then 0x00000010, bd_pend_s=0.
- Commit 8 descriptors, then a 17th we_m → free_bd=0, wr_err pulses once, and a later read of slot 0 still returns the original data.
- a_cmp held high 5 cycles after one descriptor is fully read → free_bd increments by exactly 1. A second rising edge with outstanding=0 → rel_err pulse, free_bd unchanged.
- Commit and a_cmp rising edge on the same edge with outstanding=1 → free_bd unchanged, bd_pend_s+1.
- Fill, read and release 20 descriptors with data=index → pointer wrap, and every readback matches in order.
- One word written, then flush; then write 0x1, 0x2 → free_bd=7 and readback is 0x1, 0x2. Repeat with WORDS_PER_BD=4, BD_DEPTH=4 and a rst pulse mid-descriptor → all outputs at reset values.
